rr_encoder_arbiter: RTL and testbench
=====================================

// Module: rr_encoder_arbiter
// PURPOSE
//   Round-robin arbiter for one shared 8-to-3 encoder/resource slot among 8 requesters.
//   Picks one requester, holds its grant while its request stays high (bounded by
//   MAX_HOLD), and publishes the winner as one-hot and as a 3-bit binary index.
//   Index convention: requester bit k -> gnt_idx = k (bit0 -> 3'b000, bit7 -> 3'b111).
//   Sits between the requester bank and the encoder datapath; sole owner of its sequencing.
// PARAMETERS
//   N_REQ     8   number of requesters (fixed at 8 for this revision)
//   IDX_W     3   width of gnt_idx, $clog2(N_REQ)
//   MAX_HOLD  16  max consecutive cycles one grant may be held; range 2..255
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   req        in   8      level requests, bit k = requester k
//   gnt        out  8      one-hot grant, registered; 0 when idle
//   gnt_valid  out  1      1 while a grant is held (== |gnt)
//   gnt_idx    out  3      binary index of granted requester; 0 when idle
//   timeout    out  1      1-cycle pulse on a forced release at MAX_HOLD
// BEHAVIOUR
//   Reset: gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
//   Reset assertion mid-grant clears everything immediately (async), no timeout pulse.
//   FSM states: IDLE, GRANT.
//   IDLE: if req!=0, winner = first set bit scanning ptr, ptr+1, ... 7, 0, ... ptr-1
//     (mod 8). Next edge: gnt=1<<winner, gnt_idx=winner, gnt_valid=1, hold_cnt=1,
//     -> GRANT. Latency req->gnt = 1 cycle. req==0: stay IDLE, outputs 0.
//   GRANT (holder h):
//     req[h]==0 at edge: release; gnt/gnt_valid/gnt_idx -> 0, ptr=(h+1)%8, -> IDLE.
//     req[h]==1 and hold_cnt==MAX_HOLD: forced release as above plus timeout=1
//       for exactly that one cycle.
//     else: hold, hold_cnt+=1 (8-bit, saturates never reached since bounded).
//   Each release forces one IDLE cycle (bubble) before the next grant; no back-to-back.
//   Requests from non-holders during GRANT are ignored until IDLE; they are not latched.
//   ptr wraps 7 -> 0. Ptr is updated only on release, never on grant.
//   A holder that timed out is lowest priority next round (ptr moved past it).
//   gnt is always one-hot or zero; gnt_idx always matches gnt's set bit.
//   Multiple simultaneous reqs in IDLE: exactly one winner per rule above.
// STRUCTURE
//   Shared package rr_arb_pkg: N_REQ, IDX_W, state encoding (IDLE=1'b0, GRANT=1'b1).
//   Sub-module rr_pick8: combinational; inputs req[7:0], ptr[2:0]; outputs
//     any, win_idx[2:0]. Masked priority encode (bits >= ptr) first, fallback
//     unmasked priority encode; lowest index wins within each pass.
//   Top holds FSM, ptr, hold_cnt, output registers.
// TESTING
//   1 Reset, req=8'h01 -> 1 cycle later gnt=8'h01, gnt_idx=0, gnt_valid=1.
//   2 ptr=0, req=8'h24 -> gnt=8'h04 idx=2; drop req[2] -> IDLE bubble, then
//     gnt=8'h20 idx=5; drop -> ptr=6.
//   3 ptr=6, req=8'h41|8'h01 held, releases in turn -> grants idx 6, then 0 (wrap).
//   4 req[3] held high 40 cycles, MAX_HOLD=16 -> gnt held exactly 16 cycles,
//     timeout pulse 1 cycle at release, bubble, re-grant idx 3 if alone.
//   5 Grant held on idx 5, rst_n low mid-cycle -> gnt=0, idx=0, valid=0
//     immediately; after release first grant uses ptr=0.
//   6 Random 8-bit req for 10k cycles -> gnt one-hot/zero, idx==log2(gnt),
//     no requester starved > 8*(MAX_HOLD+1) cycles.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and small helpers for the round-robin
// encoder arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (v[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_encoder_arbiter_if.sv
// Requester-bank <-> arbiter bundle: level requests in, registered grant out.
interface rr_encoder_arbiter_if;

  // Handshake: a requester raises req[k] and keeps it high for as long as it
  // wants the slot; gnt[k]/gnt_valid/gnt_idx stay asserted while the grant is
  // held; dropping req[k] releases the slot on the next edge. timeout pulses
  // for one cycle when the arbiter takes the slot away at the hold limit.
  logic [rr_arb_pkg::N_REQ-1:0] req;
  logic [rr_arb_pkg::N_REQ-1:0] gnt;
  logic                         gnt_valid;
  logic [rr_arb_pkg::IDX_W-1:0] gnt_idx;
  logic                         timeout;
  rr_arb_pkg::arb_state_t       state;

  modport master (input req, output gnt, gnt_valid, gnt_idx, timeout, state);
  modport slave  (output req, input gnt, gnt_valid, gnt_idx, timeout, state);

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first requester at or above ptr, else the
// lowest requester overall.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;

  always_comb begin
    mask = '0;
    for (int k = 0; k < N_REQ; k++) begin
      mask[k] = (k >= int'(ptr));
    end
    masked  = req & mask;
    any     = |req;
    win_idx = (|masked) ? lowest_set(masked) : lowest_set(req);
  end

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for one shared encoder slot: grants one requester,
// holds while its request stays high, force-releases after MAX_HOLD cycles.
module rr_encoder_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_encoder_arbiter_if.master bus
);

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [N_REQ-1:0] gnt_r;
  logic [IDX_W-1:0] gnt_idx_r;
  logic             gnt_valid_r;
  logic             timeout_r;

  logic             any;
  logic [IDX_W-1:0] win_idx;
  logic             holder_req;
  logic             force_now;
  logic             release_now;

  rr_pick8 u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .any     (any),
    .win_idx (win_idx)
  );

  assign holder_req  = bus.req[gnt_idx_r];
  // A dropped request wins over the hold limit, so timeout only fires when
  // the holder still wanted the slot.
  assign force_now   = holder_req && (hold_cnt == HOLD_LIMIT);
  assign release_now = !holder_req || force_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt_r       <= '0;
      gnt_idx_r   <= '0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      if (state == IDLE) begin
        if (any) begin
          gnt_r       <= idx_to_onehot(win_idx);
          gnt_idx_r   <= win_idx;
          gnt_valid_r <= 1'b1;
          hold_cnt    <= 8'd1;
          state       <= GRANT;
        end
      end else begin
        if (release_now) begin
          // ptr advances past the holder, making it lowest priority next round.
          ptr         <= gnt_idx_r + 1'b1;
          gnt_r       <= '0;
          gnt_idx_r   <= '0;
          gnt_valid_r <= 1'b0;
          hold_cnt    <= '0;
          timeout_r   <= force_now;
          state       <= IDLE;
        end else begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;
  assign bus.state     = state;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Bench for rr_encoder_arbiter: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model.
module tb_rr_encoder_arbiter;

  localparam int MAX_HOLD = 16;
  localparam int STARVE_BOUND = 8 * (MAX_HOLD + 1);

  logic clk;
  logic rst_n;

  rr_encoder_arbiter_if bus ();

  rr_encoder_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int m_holder = -1;
  int m_ptr    = 0;
  int m_cnt    = 0;
  bit m_to     = 1'b0;
  int wait_cnt [8];
  int max_wait = 0;

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_cnt    = 0;
    m_to     = 1'b0;
    for (int k = 0; k < 8; k++) wait_cnt[k] = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    m_to = 1'b0;
    if (m_holder < 0) begin
      for (int j = 0; j < 8; j++) begin
        int c;
        c = (m_ptr + j) % 8;
        if (r[c]) begin
          m_holder = c;
          m_cnt    = 1;
          break;
        end
      end
    end else if (!r[m_holder]) begin
      m_ptr    = (m_holder + 1) % 8;
      m_holder = -1;
    end else if (m_cnt == MAX_HOLD) begin
      m_ptr    = (m_holder + 1) % 8;
      m_holder = -1;
      m_to     = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [7:0] exp_gnt;
    logic [2:0] exp_idx;
    exp_gnt = '0;
    exp_idx = '0;
    if (m_holder >= 0) begin
      exp_gnt[m_holder] = 1'b1;
      exp_idx = 3'(m_holder);
    end
    check("gnt", 32'(bus.gnt), 32'(exp_gnt));
    check("gnt_idx", 32'(bus.gnt_idx), 32'(exp_idx));
    check("gnt_valid", 32'(bus.gnt_valid), 32'(m_holder >= 0));
    check("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  // ---------------- driver ----------------
  // One clock: model sees the req present at the edge, outputs checked on
  // the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(bus.req);
    @(negedge clk);
    compare_model();
    for (int k = 0; k < 8; k++) begin
      if (bus.req[k] && !bus.gnt[k]) wait_cnt[k]++;
      else wait_cnt[k] = 0;
      if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int held;
    int tos;
    logic [7:0] sticky;
    int mode;

    rst_n   = 1'b0;
    bus.req = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_gnt", 32'(bus.gnt), 32'h0);
    check("reset_idx", 32'(bus.gnt_idx), 32'h0);
    check("reset_valid", 32'(bus.gnt_valid), 32'h0);
    check("reset_timeout", 32'(bus.timeout), 32'h0);
    check("reset_state", 32'(bus.state), 32'h0);
    rst_n = 1'b1;

    // 1: single request, one-cycle latency
    bus.req = 8'h01;
    tick();
    check("t1_gnt", 32'(bus.gnt), 32'h01);
    check("t1_idx", 32'(bus.gnt_idx), 32'h0);
    check("t1_state", 32'(bus.state), 32'h1);
    bus.req = 8'h00;
    tick();

    // 2: two requesters, release then bubble then next
    bus.req = 8'h24;
    tick();
    check("t2_gnt_a", 32'(bus.gnt), 32'h04);
    check("t2_idx_a", 32'(bus.gnt_idx), 32'h2);
    bus.req = 8'h20;
    tick();
    check("t2_bubble", 32'(bus.gnt_valid), 32'h0);
    tick();
    check("t2_gnt_b", 32'(bus.gnt), 32'h20);
    check("t2_idx_b", 32'(bus.gnt_idx), 32'h5);
    bus.req = 8'h00;
    tick();

    // 3: ptr=6, wrap from 6 to 0
    bus.req = 8'h41;
    tick();
    check("t3_idx_a", 32'(bus.gnt_idx), 32'h6);
    tick();
    bus.req = 8'h01;
    tick();
    check("t3_bubble", 32'(bus.gnt_valid), 32'h0);
    tick();
    check("t3_idx_b", 32'(bus.gnt_idx), 32'h0);
    check("t3_gnt_b", 32'(bus.gnt), 32'h01);
    bus.req = 8'h00;
    tick();

    // 4: hold limit on a lone requester
    bus.req = 8'h08;
    held = 0;
    tos  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i < 17 && bus.gnt == 8'h08) held++;
      if (bus.timeout) tos++;
      if (i == 16) check("t4_release", 32'(bus.gnt_valid), 32'h0);
      if (i == 17) check("t4_regrant", 32'(bus.gnt_idx), 32'h3);
    end
    check("t4_held_cycles", 32'(held), 32'd16);
    check("t4_timeouts", 32'(tos), 32'd2);
    bus.req = 8'h00;
    tick();
    tick();

    // 5: async reset mid-grant, ptr returns to 0
    bus.req = 8'h20;
    tick();
    check("t5_pre_idx", 32'(bus.gnt_idx), 32'h5);
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(bus.gnt), 32'h0);
    check("t5_rst_idx", 32'(bus.gnt_idx), 32'h0);
    check("t5_rst_valid", 32'(bus.gnt_valid), 32'h0);
    check("t5_rst_timeout", 32'(bus.timeout), 32'h0);
    model_reset();
    bus.req = 8'hFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t5_first_idx", 32'(bus.gnt_idx), 32'h0);
    bus.req = 8'h00;
    tick();

    // 6: randomized traffic, mixing dense, sticky and sparse patterns
    apply_reset();
    max_wait = 0;
    sticky   = '0;
    mode     = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) mode = $urandom_range(0, 2);
      case (mode)
        0: bus.req = 8'($urandom);
        1: begin
          for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 15) == 0) sticky[k] = ~sticky[k];
          end
          bus.req = sticky;
        end
        default: bus.req = 8'($urandom) & 8'($urandom) & 8'($urandom);
      endcase
      tick();
      check("onehot0", 32'($onehot0(bus.gnt)), 32'h1);
      check("valid_eq_or", 32'(bus.gnt_valid), 32'(|bus.gnt));
    end
    check("no_starve", 32'(max_wait <= STARVE_BOUND), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
